// File: rtl/frame_assembler_pkg.sv
// frame_assembler_pkg: shared FSM state type and checksum width for the frame assembler.
package frame_assembler_pkg;
  typedef enum logic [1:0] {HUNT, COLLECT, CHECK} state_t;
  localparam int CSUM_W = 8;
endpackage

// File: rtl/interbyte_timer.sv
// interbyte_timer: counts idle enabled cycles and flags expiry after CYCLES of them.
// Ports: clk, rst (async, active-high), clear (restart count), enable (count allowed),
//        expired (combinational, high in the CYCLES-th consecutive idle enabled cycle).
module interbyte_timer #(
  parameter int unsigned CYCLES = 10_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int W = $clog2(CYCLES + 1);
  logic [W-1:0] r_cnt;
  // a clear in the expiry cycle suppresses the timeout
  assign expired = enable && !clear && r_cnt == W'(CYCLES - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) r_cnt <= '0;
    else if (clear || !enable || expired) r_cnt <= '0;
    else r_cnt <= r_cnt + 1'b1;
endmodule

// File: rtl/frame_assembler.sv
// frame_assembler: builds fixed-length frames from a byte stream with optional header/checksum.
// Ports: clk, rst (async, active-high); rx_data/rx_valid byte strobe in;
//        frame_data/frame_valid held until frame_ready; byte_cnt payload progress;
//        err_timeout/err_checksum/err_overflow one-cycle error pulses.
module frame_assembler
  import frame_assembler_pkg::*;
#(
  parameter int          BYTES_PER_FRAME = 6,
  parameter bit          MSB_FIRST       = 1,
  parameter bit          USE_HEADER      = 1,
  parameter logic [7:0]  HEADER_BYTE     = 8'hAA,
  parameter bit          USE_CHECKSUM    = 1,
  parameter int unsigned TIMEOUT_CYCLES  = 10_000_000
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [7:0]                           rx_data,
  input  logic                                 rx_valid,
  output logic [8*BYTES_PER_FRAME-1:0]         frame_data,
  output logic                                 frame_valid,
  input  logic                                 frame_ready,
  output logic [$clog2(BYTES_PER_FRAME+1)-1:0] byte_cnt,
  output logic                                 err_timeout,
  output logic                                 err_checksum,
  output logic                                 err_overflow
);
  localparam int BPF = BYTES_PER_FRAME;
  localparam int CW = $clog2(BPF + 1);
  localparam logic [CW-1:0] LAST = CW'(BPF - 1);
  localparam logic [CW-1:0] FULL = CW'(BPF);
  state_t r_state;
  logic [CW-1:0] r_cnt;
  logic [CSUM_W-1:0] r_sum;
  logic [8*BPF-1:0] r_buf, r_frame, w_buf;
  logic r_fvalid, r_err_to, r_err_cs, r_err_ov;
  logic w_take, w_hdr, w_last, w_chk, w_done, w_bad, w_exp, w_drop;
  // without a header, HUNT accepts the first byte as payload byte 0
  assign w_take = rx_valid && (r_state == COLLECT || (r_state == HUNT && !USE_HEADER));
  assign w_hdr  = rx_valid && r_state == HUNT && USE_HEADER && rx_data == HEADER_BYTE;
  assign w_last = w_take && r_cnt == LAST;
  assign w_chk  = rx_valid && r_state == CHECK;
  assign w_done = (w_last && !USE_CHECKSUM) || (w_chk && rx_data == r_sum);
  assign w_bad  = w_chk && rx_data != r_sum;
  assign w_drop = w_done && r_fvalid && !frame_ready;
  // payload including the byte arriving this cycle, so a checksum-less frame loads with latency 1
  always_comb begin
    w_buf = r_buf;
    for (int i = 0; i < BPF; i++)
      if (w_take && r_cnt == CW'(i)) w_buf[(MSB_FIRST ? BPF - 1 - i : i) * 8 +: 8] = rx_data;
  end
  interbyte_timer #(.CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk(clk),
    .rst(rst),
    .clear(rx_valid),
    .enable(r_state != HUNT),
    .expired(w_exp)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state  <= HUNT;
      r_cnt    <= '0;
      r_sum    <= '0;
      r_buf    <= '0;
      r_frame  <= '0;
      r_fvalid <= 1'b0;
      r_err_to <= 1'b0;
      r_err_cs <= 1'b0;
      r_err_ov <= 1'b0;
    end else begin
      r_err_to <= w_exp;
      r_err_cs <= w_bad;
      r_err_ov <= w_drop;
      if (w_take) r_buf <= w_buf;
      if (w_done && !w_drop) begin
        r_frame  <= w_buf;
        r_fvalid <= 1'b1;
      end else if (frame_ready) r_fvalid <= 1'b0;
      if (w_exp || w_chk) begin
        r_state <= HUNT;
        r_cnt   <= '0;
        r_sum   <= '0;
      end else if (w_last) begin
        r_state <= USE_CHECKSUM ? CHECK : HUNT;
        r_cnt   <= USE_CHECKSUM ? FULL : '0;
        r_sum   <= USE_CHECKSUM ? r_sum + rx_data : '0;
      end else if (w_take) begin
        r_state <= COLLECT;
        r_cnt   <= r_cnt + 1'b1;
        r_sum   <= r_sum + rx_data;
      end else if (w_hdr) r_state <= COLLECT;
    end
  assign frame_data   = r_frame;
  assign frame_valid  = r_fvalid;
  assign byte_cnt     = r_cnt;
  assign err_timeout  = r_err_to;
  assign err_checksum = r_err_cs;
  assign err_overflow = r_err_ov;
endmodule

// File: doc/frame_assembler.md
FRAME_ASSEMBLER -- requirements
Module: frame_assembler

Interface
REQ-001 Parameter BYTES_PER_FRAME, 6: payload bytes per frame, range 1..16.
REQ-002 Parameter MSB_FIRST, 1: 1 places the first payload byte in the top byte of frame_data; 0 places it in the bottom byte.
REQ-003 Parameter USE_HEADER, 1: 1 requires a header byte before the payload.
REQ-004 Parameter HEADER_BYTE, 8'hAA: header value.
REQ-005 Parameter USE_CHECKSUM, 1: 1 requires a checksum byte after the payload.
REQ-006 Parameter TIMEOUT_CYCLES, 10_000_000: maximum idle cycles between bytes inside a frame.
REQ-007 Port clk, input, 1: single clock; all logic is rising-edge.
REQ-008 Port rst, input, 1: reset, asynchronous assert, active-high.
REQ-009 Port rx_data, input, 8: received byte; qualified by rx_valid.
REQ-010 Port rx_valid, input, 1: one-cycle strobe per received byte; no backpressure exists.
REQ-011 Port frame_data, output, 8*BYTES_PER_FRAME: assembled payload.
REQ-012 Port frame_valid, output, 1: frame_data is valid.
REQ-013 Port frame_ready, input, 1: consumer accepts the frame.
REQ-014 Port byte_cnt, output, $clog2(BYTES_PER_FRAME+1): number of payload bytes collected so far.
REQ-015 Ports err_timeout, err_checksum and err_overflow, output, 1 each: one-cycle error pulses.

Function
REQ-016 The FSM shall have states HUNT, COLLECT and CHECK. HUNT shall be skipped when USE_HEADER=0. CHECK shall be skipped when USE_CHECKSUM=0.
- HUNT to COLLECT: on rx_valid with rx_data==HEADER_BYTE. Other bytes are ignored.
- With USE_HEADER=0, the first byte seen in HUNT shall be stored as payload byte 0.
REQ-017 COLLECT shall store each rx_valid byte at index byte_cnt and increment byte_cnt.
- After byte BYTES_PER_FRAME is stored: go to CHECK, or complete the frame if there is no checksum.
REQ-018 The checksum shall be the 8-bit modulo-256 sum of the payload bytes.
- A match in CHECK completes the frame.
- A mismatch pulses err_checksum, discards the frame and returns to HUNT.
REQ-019 On completion, frame_data and frame_valid shall update on the cycle after the final accepted byte (latency 1). The FSM shall return to HUNT with byte_cnt=0.
REQ-020 Once asserted, frame_valid and frame_data shall hold stable until a cycle in which frame_ready=1.
REQ-021 A frame completing while frame_valid=1 and frame_ready=0 shall be dropped. err_overflow shall pulse and the held frame shall remain unchanged.
REQ-022 If a frame completes in the same cycle as frame_valid&&frame_ready, the new frame shall load and frame_valid shall stay 1.
REQ-023 The timeout counter shall clear on every rx_valid and count only in COLLECT and CHECK.
- On reaching TIMEOUT_CYCLES: pulse err_timeout, discard the partial frame, return to HUNT and clear byte_cnt.
REQ-024 If rx_valid and timeout expiry coincide, the byte shall win and no timeout shall occur.
REQ-025 Error pulses shall not affect a frame already held on the output.

Reset
REQ-026 When rst=1, the following shall be forced immediately:
- state=HUNT, byte_cnt=0, timeout counter=0, running sum=0;
- frame_data=0, frame_valid=0, all error outputs=0.
REQ-027 Reset asserted mid-frame or mid-handshake shall discard all content, and no pulse shall be produced on release.

Structure
REQ-028 The FSM state enum and the checksum width constant shall live in the shared project package.
REQ-029 The timeout counter shall be a sub-module, interbyte_timer, with ports clk, rst, clear, enable and expired.

Verification
REQ-030 Defaults; stream AA 01 02 03 04 05 06 15 -> one cycle later frame_data=48'h010203040506 and frame_valid=1.
REQ-031 Same stream with checksum 16 -> err_checksum pulses once; frame_valid stays 0.
REQ-032 AA 01 02, then 10_000_000 idle cycles -> err_timeout pulses; a following good frame is assembled correctly.
REQ-033 Two good frames with frame_ready=0 -> the first frame is held and err_overflow pulses on completion of the second.
REQ-034 MSB_FIRST=0, USE_HEADER=0, USE_CHECKSUM=0, BYTES_PER_FRAME=4; bytes 11 22 33 44 -> frame_data=32'h44332211.
REQ-035 rst pulse after AA 01 02 -> byte_cnt=0 and frame_valid=0; the next good frame is correct.
